vga_vblank_arbiter: RTL and testbench



---
 rtl/vga_vblank_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vga_vblank_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vblank_arbiter.sv
// vga_vblank_arbiter
//   Hands out exclusive update slots to game-logic requesters only while the
//   VGA scan is in vertical blanking, so shared sprite/position state never
//   changes mid-draw. Round-robin, each requester served at most once per
//   frame, with a per-grant watchdog and forced revoke when blanking ends.
//
// Ports
//   clk_50m     : pixel clock
//   rst_n       : asynchronous active-low reset
//   vector_x    : scan x from the timing generator
//   vector_y    : scan y from the timing generator
//   req         : level request per requester, held until granted
//   done        : one-cycle completion pulse from the granted requester
//   gnt         : one-hot grant (or zero)
//   vblank      : registered (vector_y >= V_ACTIVE)
//   frame_tick  : one-cycle pulse at blanking start
//   timeout_err : one-cycle pulse when the watchdog revokes a grant
//   overrun_err : one-cycle pulse when blanking ends during a grant
//   frame_cnt   : frames elapsed, wrapping
module vga_vblank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int V_ACTIVE = 600,
  parameter int TIMEOUT  = 4095,
  parameter int CNT_W    = 12
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [10:0]      vector_x,
  input  logic [9:0]       vector_y,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             vblank,
  output logic             frame_tick,
  output logic             timeout_err,
  output logic             overrun_err,
  output logic [15:0]      frame_cnt
);

  localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]    N_REQ_W  = (IDX_W + 1)'(N_REQ);
  localparam logic [9:0]        V_FIRST  = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t           state_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] served_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] g_idx_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             vblank_reg;
  logic             frame_tick_reg;
  logic             timeout_err_reg;
  logic             overrun_err_reg;
  logic [15:0]      frame_cnt_reg;

  logic               tick_cond;
  logic               vblank_cond;
  logic [N_REQ-1:0]   pending;
  logic [2*N_REQ-1:0] pend_shift;
  logic [N_REQ-1:0]   rot_pending;
  logic [IDX_W-1:0]   first_off;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W:0]     pick_wrap;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;
  logic [N_REQ-1:0]   g_onehot;
  logic               done_g;
  logic               timeout_hit;
  logic [IDX_W-1:0]   ptr_after;

  assign tick_cond   = (vector_x == 11'd0) && (vector_y == V_FIRST);
  assign vblank_cond = (vector_y >= V_FIRST);

  // Rotate the pending vector so bit 0 is the requester at the pointer; the
  // lowest set bit then gives the round-robin offset from the pointer.
  assign pending     = req & ~served_reg;
  assign pend_shift  = {pending, pending} >> ptr_reg;
  assign rot_pending = pend_shift[N_REQ-1:0];

  always_comb begin
    first_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_pending[i]) first_off = IDX_W'(i);
    end
  end

  assign pick_sum  = {1'b0, ptr_reg} + {1'b0, first_off};
  assign pick_wrap = pick_sum - N_REQ_W;
  assign pick_idx  = (pick_sum >= N_REQ_W) ? pick_wrap[IDX_W-1:0] : pick_sum[IDX_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_decode
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
      assign g_onehot[gi]    = (g_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // done bits for any index other than the current grant are ignored.
  assign done_g      = |(done & g_onehot);
  assign timeout_hit = (cnt_reg == TO_LAST);
  assign ptr_after   = (g_idx_reg == LAST_IDX) ? '0 : g_idx_reg + 1'b1;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      served_reg      <= '0;
      ptr_reg         <= '0;
      g_idx_reg       <= '0;
      cnt_reg         <= '0;
      vblank_reg      <= 1'b0;
      frame_tick_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      vblank_reg      <= vblank_cond;
      frame_tick_reg  <= tick_cond;
      timeout_err_reg <= 1'b0;
      overrun_err_reg <= 1'b0;
      if (tick_cond) frame_cnt_reg <= frame_cnt_reg + 16'd1;

      // Blanking start always opens a fresh frame, whatever state we are in.
      if (tick_cond) begin
        served_reg <= '0;
        gnt_reg    <= '0;
        state_reg  <= ARB;
      end else begin
        case (state_reg)
          IDLE: begin
            gnt_reg <= '0;
          end
          ARB: begin
            if (!vblank_reg) begin
              state_reg <= IDLE;
            end else if (|pending) begin
              gnt_reg   <= pick_onehot;
              g_idx_reg <= pick_idx;
              cnt_reg   <= '0;
              state_reg <= GRANT;
            end
          end
          GRANT: begin
            // Overrun beats done, done beats timeout.
            if (!vblank_reg) begin
              gnt_reg         <= '0;
              overrun_err_reg <= 1'b1;
              ptr_reg         <= ptr_after;
              state_reg       <= IDLE;
            end else if (done_g || timeout_hit) begin
              gnt_reg         <= '0;
              served_reg      <= served_reg | g_onehot;
              ptr_reg         <= ptr_after;
              timeout_err_reg <= ~done_g;
              state_reg       <= ARB;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign gnt         = gnt_reg;
  assign vblank      = vblank_reg;
  assign frame_tick  = frame_tick_reg;
  assign timeout_err = timeout_err_reg;
  assign overrun_err = overrun_err_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_vblank_arbiter.sv
module tb_vga_vblank_arbiter;

  localparam int TO = 4095;

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic [10:0] vector_x = '0;
  logic [9:0]  vector_y = '0;
  logic [3:0]  req  = '0;
  logic [3:0]  done = '0;
  logic [3:0]  gnt;
  logic        vblank, frame_tick, timeout_err, overrun_err;
  logic [15:0] frame_cnt;

  vga_vblank_arbiter dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .vector_x   (vector_x),
    .vector_y   (vector_y),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .vblank     (vblank),
    .frame_tick (frame_tick),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [3:0]  gnt;
    logic        vb;
    logic        tick;
    logic        terr;
    logic        oerr;
    logic [15:0] fcnt;
    int          idx;
  } exp_t;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  e_gnt;
    logic        e_vb;
    logic        e_tick;
    logic        e_terr;
    logic        e_oerr;
  } vec_t;

  exp_t  sb[$];
  vec_t  tbl[14];
  int    err_cnt  = 0;
  int    chk_cnt  = 0;
  int    step_no  = 0;
  logic [15:0] exp_fcnt = '0;

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] req_v);
    chk_cnt++;
    if (act !== req_v) begin
      err_cnt++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, req_v);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic [10:0] x, input logic [9:0] y, input logic [3:0] r,
                      input logic [3:0] d, input logic [3:0] eg, input logic ev,
                      input logic et, input logic ete, input logic eoe);
    exp_t e;
    @(negedge clk_50m);
    vector_x = x;
    vector_y = y;
    req      = r;
    done     = d;
    if (x == 11'd0 && y == 10'd600) exp_fcnt = exp_fcnt + 16'd1;
    e.gnt  = eg;
    e.vb   = ev;
    e.tick = et;
    e.terr = ete;
    e.oerr = eoe;
    e.fcnt = exp_fcnt;
    e.idx  = step_no;
    step_no++;
    sb.push_back(e);
  endtask

  // Serve requester g for hold cycles of grant inside vblank, then done pulse.
  task automatic serve(input int g, input int hold, input logic [3:0] r);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    step(11'd5, 10'd600, r, 4'b0, oh, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < hold; k++)
      step(11'd5, 10'd600, r, 4'b0, oh, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, r, oh, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk_50m) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt",         e.idx, {12'b0, gnt},         {12'b0, e.gnt});
      chk("vblank",      e.idx, {15'b0, vblank},      {15'b0, e.vb});
      chk("frame_tick",  e.idx, {15'b0, frame_tick},  {15'b0, e.tick});
      chk("timeout_err", e.idx, {15'b0, timeout_err}, {15'b0, e.terr});
      chk("overrun_err", e.idx, {15'b0, overrun_err}, {15'b0, e.oerr});
      chk("frame_cnt",   e.idx, frame_cnt,            e.fcnt);
    end
  end

  // One line per grant transaction.
  logic [3:0] gnt_prev = '0;
  always @(posedge clk_50m) begin
    #2;
    if (gnt != 4'b0 && gnt !== gnt_prev)
      $display("grant %b at t=%0t y=%0d", gnt, $time, vector_y);
    gnt_prev = gnt;
  end

  initial begin
    // x, y, req, done, exp gnt, vblank, tick, terr, oerr
    tbl[0]  = '{11'd100,  10'd100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{11'd0,    10'd599, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{11'd1039, 10'd599, 4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{11'd0,    10'd600, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{11'd1,    10'd600, 4'b1011, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{11'd2,    10'd600, 4'b1011, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{11'd3,    10'd600, 4'b1011, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{11'd4,    10'd600, 4'b1011, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{11'd5,    10'd600, 4'b1011, 4'b0100, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{11'd6,    10'd600, 4'b1011, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{11'd7,    10'd600, 4'b1011, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{11'd8,    10'd600, 4'b1011, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{11'd9,    10'd600, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{11'd10,   10'd600, 4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk_50m);
    #2;
    chk("rst_gnt",       -1, {12'b0, gnt},         16'h0);
    chk("rst_vblank",    -1, {15'b0, vblank},      16'h0);
    chk("rst_tick",      -1, {15'b0, frame_tick},  16'h0);
    chk("rst_terr",      -1, {15'b0, timeout_err}, 16'h0);
    chk("rst_oerr",      -1, {15'b0, overrun_err}, 16'h0);
    chk("rst_frame_cnt", -1, frame_cnt,            16'h0);
    @(negedge clk_50m);
    rst_n = 1'b1;

    // Frame 1: table-driven, grants 0,1,3 and a stray done on index 2
    for (int i = 0; i < 14; i++)
      step(tbl[i].x, tbl[i].y, tbl[i].req, tbl[i].done, tbl[i].e_gnt,
           tbl[i].e_vb, tbl[i].e_tick, tbl[i].e_terr, tbl[i].e_oerr);

    // Frame 2: leave blanking, new frame, order 0,1,3 again with 10-cycle grants
    step(11'd0, 10'd0,   4'b1011, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(11'd1, 10'd0,   4'b1011, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(11'd0, 10'd600, 4'b1011, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(0, 10, 4'b1011);
    serve(1, 10, 4'b1011);
    serve(3, 10, 4'b1011);
    step(11'd5, 10'd600, 4'b1011, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Frame 3: requester 2 never finishes, watchdog revokes, then 3 is granted
    step(11'd0, 10'd0,   4'b0000, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(11'd1, 10'd0,   4'b0000, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(11'd0, 10'd600, 4'b1100, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b1100, 4'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++)
      step(11'd5, 10'd600, 4'b1100, 4'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b1100, 4'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
    step(11'd5, 10'd600, 4'b1100, 4'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b1100, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b1100, 4'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overrun: grant late in blanking, scan wraps with no done
    step(11'd1000, 10'd665, 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd1001, 10'd665, 4'b0001, 4'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd0,    10'd0,   4'b0001, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(11'd1,    10'd0,   4'b0001, 4'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(11'd2,    10'd0,   4'b0011, 4'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 4: pointer moved past 0, so 1 goes first, then 0
    step(11'd0, 10'd600, 4'b0011, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(1, 2, 4'b0011);
    serve(0, 2, 4'b0011);

    // done and timeout on the same cycle: no error, requester marked served
    step(11'd5, 10'd600, 4'b0100, 4'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++)
      step(11'd5, 10'd600, 4'b0100, 4'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b0100, 4'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd5, 10'd600, 4'b0100, 4'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-grant
    step(11'd5, 10'd600, 4'b1000, 4'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50m);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt",       -2, {12'b0, gnt},    16'h0);
    chk("async_rst_frame_cnt", -2, frame_cnt,       16'h0);
    chk("async_rst_vblank",    -2, {15'b0, vblank}, 16'h0);
    repeat (2) @(posedge clk_50m);
    @(negedge clk_50m);
    rst_n    = 1'b1;
    exp_fcnt = '0;
    step(11'd6, 10'd600, 4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd7, 10'd600, 4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd8, 10'd600, 4'b1000, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(11'd0, 10'd600, 4'b1000, 4'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(11'd1, 10'd600, 4'b1000, 4'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk_50m);
    @(negedge clk_50m);
    chk("scoreboard_drained", -3, 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
